// File: rtl/music_pkg.sv
// music_pkg: shared definitions for the melody player.
//
// Contents:
//   - state_t       : sequencer FSM state encoding (IDLE, PLAY, GAP, PAUSE)
//   - P_*           : 5-bit pitch codes (0 = rest, 1..7 low, 8..14 mid,
//                     15..21 high DO..XI, 22..31 rest)
//   - DUR_*         : 3-bit duration codes (1/4, 1/2, 3/4, 1, 2 beats)
//   - pitch_period  : pitch code -> tone period in 100 MHz clk cycles
//   - dur_mult      : duration code -> number of quarter beats
//   - song_entry    : packs {pitch, duration} into one 8-bit song-table word
package music_pkg;

    localparam int PITCH_W  = 5;
    localparam int DUR_W    = 3;
    localparam int PERIOD_W = 19;
    localparam int IDX_W    = 6;
    localparam int CNT_W    = 28;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_GAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam logic [PITCH_W-1:0] P_REST = 5'd0;
    localparam logic [PITCH_W-1:0] P_L1 = 5'd1,  P_L2 = 5'd2,  P_L3 = 5'd3,  P_L4 = 5'd4;
    localparam logic [PITCH_W-1:0] P_L5 = 5'd5,  P_L6 = 5'd6,  P_L7 = 5'd7;
    localparam logic [PITCH_W-1:0] P_M1 = 5'd8,  P_M2 = 5'd9,  P_M3 = 5'd10, P_M4 = 5'd11;
    localparam logic [PITCH_W-1:0] P_M5 = 5'd12, P_M6 = 5'd13, P_M7 = 5'd14;
    localparam logic [PITCH_W-1:0] P_H1 = 5'd15, P_H2 = 5'd16, P_H3 = 5'd17, P_H4 = 5'd18;
    localparam logic [PITCH_W-1:0] P_H5 = 5'd19, P_H6 = 5'd20, P_H7 = 5'd21;

    localparam logic [DUR_W-1:0] DUR_QTR  = 3'd0;
    localparam logic [DUR_W-1:0] DUR_HALF = 3'd1;
    localparam logic [DUR_W-1:0] DUR_3QTR = 3'd2;
    localparam logic [DUR_W-1:0] DUR_ONE  = 3'd3;
    localparam logic [DUR_W-1:0] DUR_TWO  = 3'd4;

    // Periods are round(100e6 / f) using the integer note frequencies
    // 262..494 Hz (low), 523..988 Hz (mid), 1046..1976 Hz (high).
    function automatic logic [PERIOD_W-1:0] pitch_period(input logic [PITCH_W-1:0] code);
        logic [PERIOD_W-1:0] p;
        case (code)
            5'd1:    p = 19'd381679;
            5'd2:    p = 19'd340136;
            5'd3:    p = 19'd303030;
            5'd4:    p = 19'd286533;
            5'd5:    p = 19'd255102;
            5'd6:    p = 19'd227273;
            5'd7:    p = 19'd202429;
            5'd8:    p = 19'd191205;
            5'd9:    p = 19'd170358;
            5'd10:   p = 19'd151745;
            5'd11:   p = 19'd143266;
            5'd12:   p = 19'd127551;
            5'd13:   p = 19'd113636;
            5'd14:   p = 19'd101215;
            5'd15:   p = 19'd95602;
            5'd16:   p = 19'd85106;
            5'd17:   p = 19'd75873;
            5'd18:   p = 19'd71582;
            5'd19:   p = 19'd63776;
            5'd20:   p = 19'd56818;
            5'd21:   p = 19'd50607;
            default: p = '0;
        endcase
        return p;
    endfunction

    // Unused duration codes 5..7 play as one beat.
    function automatic logic [3:0] dur_mult(input logic [DUR_W-1:0] code);
        logic [3:0] k;
        case (code)
            DUR_QTR:  k = 4'd1;
            DUR_HALF: k = 4'd2;
            DUR_3QTR: k = 4'd3;
            DUR_ONE:  k = 4'd4;
            DUR_TWO:  k = 4'd8;
            default:  k = 4'd4;
        endcase
        return k;
    endfunction

    function automatic logic [PITCH_W+DUR_W-1:0] song_entry(input logic [PITCH_W-1:0] pitch,
                                                          input logic [DUR_W-1:0]   dur);
        return {pitch, dur};
    endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational song table. Swap this file to change the song.
//
// Ports:
//   addr [5:0] : song-table entry index
//   data [7:0] : {pitch[4:0], dur[2:0]} for that entry; rest for unused slots
//
// Entries 0..3 form the short reference phrase; the remainder is a tune.
module melody_rom
    import music_pkg::*;
(
    input  logic [IDX_W-1:0]         addr,
    output logic [PITCH_W+DUR_W-1:0] data
);

    always_comb begin
        data = song_entry(P_REST, DUR_ONE);
        case (addr)
            6'd0:  data = song_entry(P_M1,   DUR_ONE);
            6'd1:  data = song_entry(P_REST, DUR_HALF);
            6'd2:  data = song_entry(P_M5,   DUR_3QTR);
            6'd3:  data = song_entry(P_L5,   DUR_QTR);
            6'd4:  data = song_entry(P_M1,   DUR_HALF);
            6'd5:  data = song_entry(P_M1,   DUR_HALF);
            6'd6:  data = song_entry(P_M5,   DUR_HALF);
            6'd7:  data = song_entry(P_M5,   DUR_HALF);
            6'd8:  data = song_entry(P_M6,   DUR_HALF);
            6'd9:  data = song_entry(P_M6,   DUR_HALF);
            6'd10: data = song_entry(P_M5,   DUR_ONE);
            6'd11: data = song_entry(P_M4,   DUR_HALF);
            6'd12: data = song_entry(P_M4,   DUR_HALF);
            6'd13: data = song_entry(P_M3,   DUR_HALF);
            6'd14: data = song_entry(P_M3,   DUR_HALF);
            6'd15: data = song_entry(P_M2,   DUR_HALF);
            6'd16: data = song_entry(P_M2,   DUR_HALF);
            6'd17: data = song_entry(P_M1,   DUR_ONE);
            6'd18: data = song_entry(P_M5,   DUR_HALF);
            6'd19: data = song_entry(P_M5,   DUR_HALF);
            6'd20: data = song_entry(P_M4,   DUR_HALF);
            6'd21: data = song_entry(P_M4,   DUR_HALF);
            6'd22: data = song_entry(P_M3,   DUR_HALF);
            6'd23: data = song_entry(P_M3,   DUR_HALF);
            6'd24: data = song_entry(P_M2,   DUR_ONE);
            6'd25: data = song_entry(P_M5,   DUR_HALF);
            6'd26: data = song_entry(P_M5,   DUR_HALF);
            6'd27: data = song_entry(P_M4,   DUR_HALF);
            6'd28: data = song_entry(P_M4,   DUR_HALF);
            6'd29: data = song_entry(P_M3,   DUR_HALF);
            6'd30: data = song_entry(P_M3,   DUR_HALF);
            6'd31: data = song_entry(P_M2,   DUR_ONE);
            6'd32: data = song_entry(P_H1,   DUR_QTR);
            6'd33: data = song_entry(P_M7,   DUR_QTR);
            6'd34: data = song_entry(P_M6,   DUR_HALF);
            6'd35: data = song_entry(P_M1,   DUR_TWO);
            default: data = song_entry(P_REST, DUR_ONE);
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through the song table in melody_rom and drives a
// downstream tone generator with a period and a gate.
//
// Build option: define MELODY_SEQ_GAP_EN to add a GAP_CYCLES-long silent
// articulation gap at the end of every note. Without it each note sounds for
// its full length and repeated equal notes run together.
//
// Ports:
//   clk, rst_n   : 100 MHz clock, asynchronous active-low reset
//   start        : pulse, (re)start playback at entry 0
//   stop         : pulse, abort playback to IDLE (no done pulse)
//   pause        : pulse, toggle pause/resume while playing (ignored in IDLE)
//   loop_en      : level, wrap from the last entry to entry 0
//   note_period  : tone period in clk cycles, 0 for silence/rest
//   note_gate    : high while the tone must sound
//   note_idx     : current song-table entry
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse when the song ends with loop_en low
//   state        : current FSM state, for observation
//
// Control pulses are single-cycle strobes sampled on every rising clk edge;
// there is no back-pressure. Simultaneous pulses resolve stop > start > pause.
// All outputs are registered and change on the edge that samples the pulse.
module melody_sequencer
    import music_pkg::*;
#(
    parameter int BEAT_CYCLES = 100_000_000,
    parameter int SONG_LEN    = 36,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                loop_en,
    output logic [PERIOD_W-1:0] note_period,
    output logic                note_gate,
    output logic [IDX_W-1:0]    note_idx,
    output logic                busy,
    output logic                done,
    output state_t              state
);

    localparam logic [CNT_W-1:0] QUARTER  = CNT_W'(BEAT_CYCLES / 4);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
`ifdef MELODY_SEQ_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_CYCLES);
`endif

    if (SONG_LEN < 1 || SONG_LEN > 64 || GAP_CYCLES >= BEAT_CYCLES / 4) begin : g_param_check
        $error("melody_sequencer: SONG_LEN or GAP_CYCLES out of range");
    end

    state_t                     saved;      // state to resume into after PAUSE
    logic [CNT_W-1:0]           cnt;        // cycles elapsed in the current entry
    logic [CNT_W-1:0]           len;        // length of the current entry

    state_t                     state_d, saved_d, run_state;
    logic [CNT_W-1:0]           cnt_d, len_d, run_cnt;
    logic [PERIOD_W-1:0]        period_d;
    logic                       gate_d, done_d, run_next, run_end;
    logic [IDX_W-1:0]           idx_d, fetch_idx;
    logic [PITCH_W+DUR_W-1:0]   rom_data;
    logic [PERIOD_W-1:0]        entry_period;
    logic [CNT_W-1:0]           entry_len;

    // The ROM is always addressed with the entry that would be loaded next,
    // so a new note's period and length are ready on the loading edge.
    always_comb begin
        fetch_idx = (start || note_idx == LAST_IDX) ? '0 : note_idx + 6'd1;
    end

    melody_rom u_rom (
        .addr (fetch_idx),
        .data (rom_data)
    );

    assign entry_period = pitch_period(rom_data[DUR_W +: PITCH_W]);
    assign entry_len    = QUARTER * CNT_W'(dur_mult(rom_data[DUR_W-1:0]));

    // One step of a running note: either the entry finishes, or the count
    // advances (entering GAP once the sounding part is used up).
    always_comb begin
        run_state = state;
        run_cnt   = cnt + 28'd1;
        run_next  = 1'b0;
        if (state == S_PLAY || state == S_GAP) begin
            if (cnt == len - 28'd1) begin
                run_next = 1'b1;
            end
`ifdef MELODY_SEQ_GAP_EN
            else if (state == S_PLAY && run_cnt == len - GAP_LEN) begin
                run_state = S_GAP;
            end
`endif
        end
    end

    assign run_end = run_next && (note_idx == LAST_IDX) && !loop_en;

    always_comb begin
        state_d  = state;
        saved_d  = saved;
        cnt_d    = cnt;
        len_d    = len;
        period_d = note_period;
        gate_d   = note_gate;
        idx_d    = note_idx;
        done_d   = 1'b0;

        if (stop) begin
            state_d  = S_IDLE;
            saved_d  = S_IDLE;
            cnt_d    = '0;
            period_d = '0;
            gate_d   = 1'b0;
            idx_d    = '0;
        end else if (start) begin
            state_d  = S_PLAY;
            saved_d  = S_PLAY;
            cnt_d    = '0;
            len_d    = entry_len;
            period_d = entry_period;
            gate_d   = (entry_period != '0);
            idx_d    = '0;
        end else begin
            case (state)
                S_PLAY, S_GAP: begin
                    if (run_end) begin
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                        period_d = '0;
                        gate_d   = 1'b0;
                        idx_d    = '0;
                        done_d   = 1'b1;
                    end else begin
                        if (run_next) begin
                            state_d  = S_PLAY;
                            cnt_d    = '0;
                            len_d    = entry_len;
                            period_d = entry_period;
                            idx_d    = fetch_idx;
                        end else begin
                            state_d = run_state;
                            cnt_d   = run_cnt;
                        end
                        gate_d = (state_d == S_PLAY) && (period_d != '0);
                        // The pausing edge still counts as a played cycle, so
                        // paused time is excluded exactly from the note length.
                        if (pause) begin
                            saved_d = state_d;
                            state_d = S_PAUSE;
                            gate_d  = 1'b0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (pause) begin
                        state_d = saved;
                        gate_d  = (saved == S_PLAY) && (note_period != '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            saved       <= S_IDLE;
            cnt         <= '0;
            len         <= '0;
            note_period <= '0;
            note_gate   <= 1'b0;
            note_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            saved       <= saved_d;
            cnt         <= cnt_d;
            len         <= len_d;
            note_period <= period_d;
            note_gate   <= gate_d;
            note_idx    <= idx_d;
            busy        <= (state_d != S_IDLE);
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed self-checking bench for melody_sequencer with
// BEAT_CYCLES=40, GAP_CYCLES=2, SONG_LEN=4 over the reference phrase
// {mid DO,1}, {rest,1/2}, {mid SO,3/4}, {low SO,1/4}.
// Expectations follow the build: MELODY_SEQ_GAP_EN selects the gap timing.
module tb_melody_sequencer;
    import music_pkg::*;

`ifdef MELODY_SEQ_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic        clk, rst_n, start, stop, pause, loop_en;
    logic [18:0] note_period;
    logic        note_gate, busy, done;
    logic [5:0]  note_idx;
    state_t      state;

    melody_sequencer #(
        .BEAT_CYCLES (40),
        .SONG_LEN    (4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .note_period (note_period),
        .note_gate   (note_gate),
        .note_idx    (note_idx),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_seen = 0;

    typedef struct {
        int          cyc;
        logic [18:0] period;
        logic        gate_g;
        logic        gate_n;
        logic [5:0]  idx;
        logic        busy;
        logic        done;
        state_t      st_g;
    } vec_t;

    vec_t vecs[19];

    // One clock: inputs seen at the rising edge, outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (done) done_seen++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " period"}, 32'(note_period), 32'd0);
        check({tag, " gate"},   32'(note_gate),   32'd0);
        check({tag, " idx"},    32'(note_idx),    32'd0);
        check({tag, " busy"},   32'(busy),        32'd0);
        check({tag, " done"},   32'(done),        32'd0);
        check({tag, " state"},  32'(state),       32'(S_IDLE));
    endtask

    initial begin
        int t0;
        int gate_low, run_cycles, run_high, pause_cycles, pause_gate_hi, pause_period_bad;
        state_t exp_st;

        // cycle, period, gate(gap build), gate(no-gap build), idx, busy, done, state(gap build)
        vecs[0]  = '{10,  19'd0,      1'b0, 1'b0, 6'd0, 1'b0, 1'b0, S_IDLE};
        vecs[1]  = '{11,  19'd191205, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0, S_PLAY};
        vecs[2]  = '{48,  19'd191205, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0, S_PLAY};
        vecs[3]  = '{49,  19'd191205, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, S_GAP};
        vecs[4]  = '{50,  19'd191205, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, S_GAP};
        vecs[5]  = '{51,  19'd0,      1'b0, 1'b0, 6'd1, 1'b1, 1'b0, S_PLAY};
        vecs[6]  = '{68,  19'd0,      1'b0, 1'b0, 6'd1, 1'b1, 1'b0, S_PLAY};
        vecs[7]  = '{69,  19'd0,      1'b0, 1'b0, 6'd1, 1'b1, 1'b0, S_GAP};
        vecs[8]  = '{70,  19'd0,      1'b0, 1'b0, 6'd1, 1'b1, 1'b0, S_GAP};
        vecs[9]  = '{71,  19'd127551, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0, S_PLAY};
        vecs[10] = '{98,  19'd127551, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0, S_PLAY};
        vecs[11] = '{99,  19'd127551, 1'b0, 1'b1, 6'd2, 1'b1, 1'b0, S_GAP};
        vecs[12] = '{100, 19'd127551, 1'b0, 1'b1, 6'd2, 1'b1, 1'b0, S_GAP};
        vecs[13] = '{101, 19'd255102, 1'b1, 1'b1, 6'd3, 1'b1, 1'b0, S_PLAY};
        vecs[14] = '{108, 19'd255102, 1'b1, 1'b1, 6'd3, 1'b1, 1'b0, S_PLAY};
        vecs[15] = '{109, 19'd255102, 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, S_GAP};
        vecs[16] = '{110, 19'd255102, 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, S_GAP};
        vecs[17] = '{111, 19'd0,      1'b0, 1'b0, 6'd0, 1'b0, 1'b1, S_IDLE};
        vecs[18] = '{112, 19'd0,      1'b0, 1'b0, 6'd0, 1'b0, 1'b0, S_IDLE};

        // Clock/reset
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        cyc = 0;
        done_seen = 0;

        // Full pass, loop_en low, start driven in cycle 10
        for (int i = 0; i < 19; i++) begin
            while (cyc < vecs[i].cyc) begin
                start = (cyc == 10);
                tick();
                start = 1'b0;
            end
            exp_st = (!GAP_ON && vecs[i].st_g == S_GAP) ? S_PLAY : vecs[i].st_g;
            check($sformatf("v%0d period", i), 32'(note_period), 32'(vecs[i].period));
            check($sformatf("v%0d gate", i),   32'(note_gate),   32'(GAP_ON ? vecs[i].gate_g : vecs[i].gate_n));
            check($sformatf("v%0d idx", i),    32'(note_idx),    32'(vecs[i].idx));
            check($sformatf("v%0d busy", i),   32'(busy),        32'(vecs[i].busy));
            check($sformatf("v%0d done", i),   32'(done),        32'(vecs[i].done));
            check($sformatf("v%0d state", i),  32'(state),       32'(exp_st));
        end
        repeat (10) tick();
        check("pass done count", 32'(done_seen), 32'd1);

        // Looping: entry 3 -> 0 with no idle cycle, never done
        loop_en = 1'b1;
        done_seen = 0;
        gate_low = 0;
        t0 = cyc;
        while (cyc < t0 + 210) begin
            start = (cyc == t0);
            tick();
            start = 1'b0;
            if (cyc >= t0 + 61 && cyc <= t0 + 130 && !note_gate) gate_low++;
            if (cyc == t0 + 100) check("loop idx3", 32'(note_idx), 32'd3);
            if (cyc == t0 + 101) begin
                check("loop wrap idx",    32'(note_idx),    32'd0);
                check("loop wrap period", 32'(note_period), 32'd191205);
                check("loop wrap gate",   32'(note_gate),   32'd1);
                check("loop wrap busy",   32'(busy),        32'd1);
            end
            if (cyc == t0 + 201) check("loop 2nd wrap idx", 32'(note_idx), 32'd0);
        end
        check("loop done count", 32'(done_seen), 32'd0);
        check("loop gate-low cycles", 32'(gate_low), GAP_ON ? 32'd4 : 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("stop");
        loop_en = 1'b0;

        // Pause 5 cycles into entry 2, resume 50 cycles later
        done_seen = 0;
        run_cycles = 0; run_high = 0; pause_cycles = 0; pause_gate_hi = 0; pause_period_bad = 0;
        t0 = cyc;
        while (cyc < t0 + 160) begin
            start = (cyc == t0);
            pause = (cyc == t0 + 65) || (cyc == t0 + 115);
            tick();
            start = 1'b0;
            pause = 1'b0;
            if (state == S_PAUSE) begin
                pause_cycles++;
                if (note_gate) pause_gate_hi++;
                if (note_period != 19'd127551) pause_period_bad++;
            end else if (note_idx == 6'd2 && busy) begin
                run_cycles++;
                if (note_gate) run_high++;
            end
            if (cyc == t0 + 141) check("pause next idx", 32'(note_idx), 32'd3);
        end
        check("pause cycles",        32'(pause_cycles),     32'd50);
        check("pause gate high",     32'(pause_gate_hi),    32'd0);
        check("pause period held",   32'(pause_period_bad), 32'd0);
        check("entry2 run cycles",   32'(run_cycles),       32'd30);
        check("entry2 gate cycles",  32'(run_high),         GAP_ON ? 32'd28 : 32'd30);
        check("pause done count",    32'(done_seen),        32'd1);

        // Restart while busy, then stop+start+pause together
        done_seen = 0;
        t0 = cyc;
        while (cyc < t0 + 120) begin
            start = (cyc == t0) || (cyc == t0 + 70) || (cyc == t0 + 115);
            stop  = (cyc == t0 + 115);
            pause = (cyc == t0 + 115);
            tick();
            start = 1'b0; stop = 1'b0; pause = 1'b0;
            if (cyc == t0 + 71) begin
                check("restart idx",    32'(note_idx),    32'd0);
                check("restart period", 32'(note_period), 32'd191205);
                check("restart gate",   32'(note_gate),   32'd1);
            end
            if (cyc == t0 + 110) check("restart full length idx", 32'(note_idx), 32'd0);
            if (cyc == t0 + 111) check("restart next idx", 32'(note_idx), 32'd1);
            if (cyc == t0 + 116) check_idle("stop+start+pause");
        end
        check("stop no done", 32'(done_seen), 32'd0);

        // Pause in IDLE is ignored
        pause = 1'b1;
        tick();
        pause = 1'b0;
        check_idle("idle pause");

        // Asynchronous reset mid entry 2, then restart from entry 0
        t0 = cyc;
        while (cyc < t0 + 75) begin
            start = (cyc == t0);
            tick();
            start = 1'b0;
        end
        check("pre-reset idx", 32'(note_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle("post-reset hold");
        t0 = cyc;
        while (cyc < t0 + 41) begin
            start = (cyc == t0);
            tick();
            start = 1'b0;
            if (cyc == t0 + 1) begin
                check("post-reset idx",    32'(note_idx),    32'd0);
                check("post-reset period", 32'(note_period), 32'd191205);
                check("post-reset state",  32'(state),       32'(S_PLAY));
            end
        end
        check("post-reset entry1", 32'(note_idx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 100_000_000, meaning clk cycles per one-beat note.
REQ-002 SHALL have parameter SONG_LEN, default 36, meaning number of song-table entries, range 1..64.
REQ-003 SHALL have parameter GAP_CYCLES, default 5_000_000, meaning articulation silence per note, less than BEAT_CYCLES/4.
REQ-004 SHALL have port clk, input, 1 bit: system clock, 100 MHz.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that starts playback from entry 0.
REQ-007 SHALL have port stop, input, 1 bit: one-cycle pulse that aborts playback.
REQ-008 SHALL have port pause, input, 1 bit: one-cycle pulse that toggles pause/resume.
REQ-009 SHALL have port loop_en, input, 1 bit: level; when high, playback restarts at entry 0 after the last entry.
REQ-010 SHALL have port note_period, output, 19 bits: clk cycles per tone period, consumed by the downstream tone generator.
REQ-011 SHALL have port note_gate, output, 1 bit: high while the tone must sound.
REQ-012 SHALL have port note_idx, output, 6 bits: current song-table entry.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the last entry ends with loop_en low.

Function
REQ-015 SHALL fetch each entry from the song table as a 5-bit pitch code and a 3-bit duration code.
REQ-016 SHALL map pitch codes as: 0=rest; 1..7=low DO..XI; 8..14=mid DO..XI; 15..21=high DO..XI; 22..31=rest.
REQ-017 SHALL set note_period to round(100e6/f) (e.g. mid DO=191205, low SO=255102) and to 0 for a rest.
REQ-018 SHALL map duration codes 0..4 to 1/4, 1/2, 3/4, 1 and 2 beats, with codes 5..7 treated as 1 beat.
REQ-019 SHALL compute duration length as (BEAT_CYCLES/4)*k, k in {1,2,3,4,8}, using a 28-bit duration counter.
REQ-020 SHALL implement states IDLE, PLAY, GAP and PAUSE.
REQ-021 SHALL go IDLE->PLAY on start; note_idx=0 and note_period/note_gate are valid on the following clk edge (1-cycle latency).
REQ-022 SHALL hold note_gate high in PLAY except for rests, where note_gate is low.
REQ-023 SHALL go PLAY->GAP when the duration count reaches length-GAP_CYCLES, then GAP->next entry when the count reaches length; note_gate is low in GAP.
REQ-024 SHALL, after the last entry with loop_en high, set note_idx to 0 with no extra idle cycle; with loop_en low, go to IDLE and pulse done.
REQ-025 SHALL, on pause in PLAY or GAP, go to PAUSE: duration counter frozen, note_gate low, note_period held.
REQ-026 SHALL, on pause in PAUSE, return to the saved state and continue counting.
REQ-027 SHALL, on stop in any state, go to IDLE within 1 cycle with note_gate=0, note_period=0, note_idx=0 and no done pulse.
REQ-028 SHALL resolve simultaneous pulses with priority stop > start > pause.
REQ-029 SHALL, on start while busy, restart at entry 0 with the duration counter cleared.
REQ-030 SHALL ignore pause in IDLE.
REQ-031 SHALL register all outputs.

Reset
REQ-032 SHALL, on rst_n low, force state=IDLE, note_period=0, note_gate=0, note_idx=0, busy=0, done=0 and duration counter=0, asynchronously, mid-note included.
REQ-033 SHALL leave IDLE only on a start pulse after reset release.

Configuration
REQ-034 SHALL, with macro MELODY_SEQ_GAP_EN defined, implement the GAP state per REQ-023.
REQ-035 SHALL, without MELODY_SEQ_GAP_EN, omit GAP: each note holds note_gate for its full length, GAP_CYCLES is unused, and repeated equal notes sound joined.

Structure
REQ-036 SHALL take the pitch-period constant table, duration-code encodings and the state enum from shared package music_pkg.
REQ-037 SHALL hold the song table in sub-module melody_rom (6-bit addr in, 8-bit {pitch,dur} out, combinational) so songs are swapped without touching the sequencer.

Verification (BEAT_CYCLES=40, GAP_CYCLES=2, SONG_LEN=4, table {mid DO,1 beat},{rest,1/2},{mid SO,3/4},{low SO,1/4})
REQ-038 SHALL verify: start at cycle 10 -> cycle 11 note_period=191205, gate=1; gate low cycles 49..50; idx=1 at cycle 51 with gate=0 (rest) for 20 cycles.
REQ-039 SHALL verify: full pass, loop_en=0 -> done pulses once after 40+20+30+10=100 cycles; busy falls the same cycle.
REQ-040 SHALL verify: loop_en=1 -> note_idx goes 3->0 with no idle cycle; done never pulses.
REQ-041 SHALL verify: pause 5 cycles into entry 2, resume after 50 cycles -> gate low while paused; entry 2 lasts 30 sounding-plus-gap cycles excluding the pause.
REQ-042 SHALL verify: stop+start+pause in the same cycle -> IDLE, all outputs 0.
REQ-043 SHALL verify: rst_n low mid-entry 2, then start -> playback resumes from entry 0; build without MELODY_SEQ_GAP_EN -> gate never drops between non-rest notes.
